memory_burst_ctrl: RTL and testbench
====================================

# memory_burst_ctrl

Parametrised synchronous single-port memory with a built-in burst engine. It generalises our address/data/read_en/en memory to configurable width and depth. It adds registered reads, writes, multi-word bursts with address wrap-around, and an enable-based stall. It sits between a host sequencer and storage: the host issues one start command and then streams words in or out under a valid/ready handshake.

## Interface
- N, default 2: size parameter. ADDR_W = 2*N and DATA_W = 2*N unless overridden.
- ADDR_W, default 2*N: address width. Depth is 2**ADDR_W words.
- DATA_W, default 2*N: word width.
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable. When low, the engine holds state and performs no transfer.
- start  in  1  burst request. Sampled in IDLE only, and only when en=1.
- write_mode  in  1  sampled with start. 1 selects a write burst, 0 a read burst.
- base_addr  in  ADDR_W  first word address, sampled with start.
- len  in  ADDR_W  burst length minus one (0 means 1 word, all-ones means 2**ADDR_W words). Sampled with start.
- wr_data  in  DATA_W  write word.
- wr_valid  in  1  wr_data is valid.
- wr_ready  out  1  combinational: (state==WRITE) && en.
- rd_data  out  DATA_W  registered read word.
- rd_valid  out  1  one-cycle qualifier for rd_data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on burst completion.

## Operation
- States: IDLE, READ, WRITE. Internal registers: ptr (ADDR_W) and cnt (ADDR_W).
- IDLE: on an edge with en && start:
  - ptr <= base_addr, cnt <= len.
  - Go to WRITE if write_mode=1, otherwise READ.
  - start is ignored in READ and WRITE.
- READ, on each edge with en=1:
  - rd_data <= mem[ptr], rd_valid <= 1, ptr <= ptr+1, cnt <= cnt-1.
  - If cnt==0: done <= 1 and go to IDLE.
- READ, on an edge with en=0: rd_valid <= 0 and ptr/cnt hold.
- WRITE, on each edge with wr_valid && wr_ready:
  - mem[ptr] <= wr_data, ptr <= ptr+1, cnt <= cnt-1.
  - If cnt==0: done <= 1 and go to IDLE.
- WRITE without a handshake: no write, and ptr/cnt hold.
- Address arithmetic is modulo 2**ADDR_W. A burst crossing the top address wraps to 0. A full-depth burst touches every word exactly once.
- rd_valid and done are cleared on every edge that does not set them, so both are single-cycle pulses.
- rd_data holds its last value when rd_valid=0.
- Memory contents are not reset. They power up undefined and survive rst.
- Reset mid-burst:
  - The state goes to IDLE immediately.
  - Words already written remain. No further words are written.
  - An in-flight read word is discarded (rd_valid=0).

## Timing
- Reset values: rd_data=0, rd_valid=0, done=0, busy=0, wr_ready=0, state=IDLE, ptr=0, cnt=0.
- Read burst, with start sampled at edge k and en held high:
  - busy is high after edge k.
  - Word i appears with rd_valid at edge k+1+i, i = 0..len.
  - done is asserted together with the last rd_valid, at edge k+1+len.
  - busy is low after that edge.
- Read latency: 1 cycle from the address being issued internally to rd_data.
- Write burst:
  - wr_ready is high from the cycle after the start edge.
  - Each accepted word takes 1 cycle.
  - done is asserted at the edge that writes the last word, and wr_ready drops after it.
- Back-to-back bursts: a start asserted in the cycle where done=1 is sampled in IDLE at the next edge and accepted. There is no dead cycle beyond that.
- Each en=0 cycle extends a burst by exactly one cycle. No word is skipped or duplicated.

## Test plan
- Reset: pulse rst asynchronously, mid-cycle -> rd_valid=0, done=0, busy=0, wr_ready=0, rd_data=4'h0 immediately, without waiting for a clock edge.
- Full-depth round trip (defaults): write base=0, len=15, data=i^4'hA -> 16 accepted writes and done on the 16th. Then read base=0, len=15 -> rd_data = A,B,8,9,…,5 on 16 consecutive rd_valid cycles, with done on the last.
- Wrap-around: write base=14, len=3, data 1,2,3,4 -> read base=14, len=3 returns 1,2,3,4. A single-word read at addr 0 returns 3, and addr 2 keeps its prior value.
- Stalls:
  - Read burst of 4 with en=0 for 2 cycles after the second word -> 4 rd_valid pulses, in order, ending 2 cycles later than unstalled.
  - Write burst with wr_valid gaps -> only handshaked words are stored, at consecutive addresses.
- Command rules: start pulsed during a busy read is ignored (no effect on ptr or data). A new start asserted in the done cycle begins at the next edge, with its first rd_valid 2 edges after done.
- Reset mid-write: write base=4, len=7, assert rst after 2 accepted words -> busy=0 and done never pulses. Reading 4..5 returns the written words, and 6..11 keep their old contents.

Source files
------------

// File: rtl/memory_burst_ctrl_if.sv
// +----------------------------------------------------------------------+
// | memory_burst_ctrl_if                                                 |
// | Host-side command, write-stream and read-stream bundle for the       |
// | memory_burst_ctrl burst engine.                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface memory_burst_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              en;
  logic              start;
  logic              write_mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;

  modport master (
    output en, start, write_mode, base_addr, len, wr_data, wr_valid,
    input  wr_ready, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  en, start, write_mode, base_addr, len, wr_data, wr_valid,
    output wr_ready, rd_data, rd_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/memory_burst_ctrl.sv
// +----------------------------------------------------------------------+
// | memory_burst_ctrl                                                    |
// | Single-port memory with a start-triggered read/write burst engine,   |
// | wrapping addresses and an enable-based stall.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module memory_burst_ctrl #(
  parameter int N      = 2,
  parameter int ADDR_W = 2 * N,
  parameter int DATA_W = 2 * N
) (
  input  wire logic          clk,
  input  wire logic          rst,
  memory_burst_ctrl_if.slave bus
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_done;
  logic [DATA_W-1:0] r_mem [c_DEPTH];

  logic              w_load;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_rd_fire    = 1'b0;
    w_wr_fire    = 1'b0;
    w_last       = (r_cnt == '0);
    case (r_state)
      S_IDLE: begin
        if (bus.en && bus.start) begin
          w_load       = 1'b1;
          w_next_state = bus.write_mode ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (bus.en) begin
          w_rd_fire = 1'b1;
          if (w_last) begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (bus.en && bus.wr_valid) begin
          w_wr_fire = 1'b1;
          if (w_last) begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // cnt counts remaining words minus one; ptr wraps naturally at ADDR_W bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      r_done     <= (w_rd_fire || w_wr_fire) && w_last;
      if (w_load) begin
        r_ptr <= bus.base_addr;
        r_cnt <= bus.len;
      end else if (w_rd_fire || w_wr_fire) begin
        r_ptr <= r_ptr + 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_rd_fire) begin
        r_rd_data <= r_mem[r_ptr];
      end
    end
  end

  // Storage is never reset; during rst the state is IDLE so no write can fire
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_ptr] <= bus.wr_data;
    end
  end

  assign bus.wr_ready = (r_state == S_WRITE) && bus.en;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_memory_burst_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_memory_burst_ctrl                                                 |
// | Directed and randomized bursts against a word-array reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_memory_burst_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] ref_mem [16];

  memory_burst_ctrl_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  memory_burst_ctrl #(.N(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag, input int cyc);
    checks++;
    errors++;
    $error("FAIL %s observed=%0d cycles expected=burst completion", tag, cyc);
  endtask

  // Called and returns at a negedge. abort_after>=0 fires rst before that word's edge.
  task automatic write_burst(input logic [3:0] base, input logic [3:0] len,
                             input logic [3:0] data[$], input bit gaps,
                             input int abort_after);
    int         acc = 0;
    int         cyc = 0;
    bit         hs;
    logic [3:0] a;
    bus.en = 1'b1; bus.start = 1'b1; bus.write_mode = 1'b1;
    bus.base_addr = base; bus.len = len;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.write_mode = 1'($urandom);
    bus.base_addr = 4'($urandom); bus.len = 4'($urandom);
    chk("wr_busy", 32'(bus.busy), 1);
    while (acc <= int'(len)) begin
      if (cyc > 400) begin timeout("wr_timeout", cyc); break; end
      bus.en       = gaps ? ($urandom_range(0, 4) != 0) : 1'b1;
      bus.wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.wr_data  = data[acc];
      if (abort_after == acc) begin
        bus.en = 1'b1; bus.wr_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_wr_ready", 32'(bus.wr_ready), 0);
        chk("abort_done", 32'(bus.done), 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; bus.wr_valid = 1'b0;
        return;
      end
      #1 chk("wr_ready", 32'(bus.wr_ready), 32'(bus.en));
      hs = bus.en && bus.wr_valid;
      @(posedge clk); @(negedge clk);
      if (hs) begin
        a = base + 4'(acc);
        ref_mem[a] = data[acc];
        chk("wr_done", 32'(bus.done), 32'(acc == int'(len)));
        acc++;
      end else begin
        chk("wr_done_nohs", 32'(bus.done), 0);
      end
      cyc++;
    end
    bus.wr_valid = 1'b0;
    bus.en = 1'b1;
    chk("wr_end_busy", 32'(bus.busy), 0);
    chk("wr_end_ready", 32'(bus.wr_ready), 0);
  endtask

  // Called and returns at a negedge, so a following call starts in the done cycle.
  task automatic read_burst(input logic [3:0] base, input logic [3:0] len,
                            input bit rand_stall, input int force_after,
                            input int force_cycles, input bit poke);
    int         i = 0;
    int         forced = 0;
    int         cyc = 0;
    bit         en_now;
    logic [3:0] a;
    logic [3:0] last_word = 4'h0;
    bus.en = 1'b1; bus.start = 1'b1; bus.write_mode = 1'b0;
    bus.base_addr = base; bus.len = len;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("rd_busy", 32'(bus.busy), 1);
    while (i <= int'(len)) begin
      if (cyc > 400) begin timeout("rd_timeout", cyc); break; end
      if (i == force_after && forced < force_cycles) begin
        en_now = 1'b0;
        forced++;
      end else begin
        en_now = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      bus.en = en_now;
      if (poke && i < int'(len) && $urandom_range(0, 1) == 1) begin
        bus.start = 1'b1;
        bus.write_mode = 1'($urandom);
        bus.base_addr = 4'($urandom);
        bus.len = 4'($urandom);
      end
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      if (en_now) begin
        a = base + 4'(i);
        chk("rd_valid", 32'(bus.rd_valid), 1);
        chk("rd_data", 32'(bus.rd_data), 32'(ref_mem[a]));
        chk("rd_done", 32'(bus.done), 32'(i == int'(len)));
        last_word = ref_mem[a];
        i++;
      end else begin
        chk("rd_stall_valid", 32'(bus.rd_valid), 0);
        chk("rd_stall_done", 32'(bus.done), 0);
        if (i > 0) chk("rd_stall_hold", 32'(bus.rd_data), 32'(last_word));
      end
      cyc++;
    end
    bus.en = 1'b1;
    chk("rd_end_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    logic [3:0] q[$];
    logic [3:0] b;
    logic [3:0] l;

    rst = 1'b1;
    bus.en = 1'b0; bus.start = 1'b0; bus.write_mode = 1'b0;
    bus.base_addr = '0; bus.len = '0; bus.wr_data = '0; bus.wr_valid = 1'b0;
    #1;
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a read burst
    bus.en = 1'b1; bus.start = 1'b1; bus.write_mode = 1'b0;
    bus.base_addr = 4'd0; bus.len = 4'd3;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("pre_rst_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_valid", 32'(bus.rd_valid), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_wr_ready", 32'(bus.wr_ready), 0);
    chk("arst_rd_data", 32'(bus.rd_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // Full-depth round trip
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(4'(i) ^ 4'hA);
    write_burst(4'd0, 4'd15, q, 1'b0, -1);
    read_burst(4'd0, 4'd15, 1'b0, -1, 0, 1'b0);

    // Wrap-around across the top address, then back-to-back single reads
    q = '{4'd1, 4'd2, 4'd3, 4'd4};
    write_burst(4'd14, 4'd3, q, 1'b0, -1);
    read_burst(4'd14, 4'd3, 1'b0, -1, 0, 1'b0);
    read_burst(4'd0, 4'd0, 1'b0, -1, 0, 1'b0);
    read_burst(4'd2, 4'd0, 1'b0, -1, 0, 1'b0);

    // Two-cycle enable stall after the second word of a 4-word read
    read_burst(4'd5, 4'd3, 1'b0, 2, 2, 1'b0);

    // Write with handshake gaps, then read back
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(4'($urandom));
    write_burst(4'd9, 4'd5, q, 1'b1, -1);
    read_burst(4'd9, 4'd5, 1'b0, -1, 0, 1'b0);

    // Starts pulsed while a read is busy must be ignored
    read_burst(4'd3, 4'd9, 1'b0, -1, 0, 1'b1);

    // Reset after two accepted words of an 8-word write
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(4'($urandom));
    write_burst(4'd4, 4'd7, q, 1'b0, 2);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("post_abort_done", 32'(bus.done), 0);
      chk("post_abort_busy", 32'(bus.busy), 0);
    end
    read_burst(4'd4, 4'd7, 1'b0, -1, 0, 1'b0);

    // Randomized mixed traffic
    for (int n = 0; n < 20; n++) begin
      b = 4'($urandom);
      l = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        q = {};
        for (int i = 0; i <= int'(l); i++) q.push_back(4'($urandom));
        write_burst(b, l, q, 1'($urandom), -1);
      end else begin
        read_burst(b, l, 1'($urandom), -1, 0, 1'($urandom));
      end
    end
    read_burst(4'd0, 4'd15, 1'b1, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
